channel: RTL and testbench
==========================

CHANNEL -- requirements
Module: channel

Interface
REQ-001 Parameter WIDTH, default 8, data bit width of one transfer token.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 s_req  input  1  sender request, 4-phase, level.
REQ-005 s_data  input  WIDTH  sender data, bundled with s_req; stable while s_req high.
REQ-006 s_ack  output  1  sender acknowledge, registered.
REQ-007 r_req  output  1  receiver request, registered; r_data valid while high.
REQ-008 r_data  output  WIDTH  receiver data, registered.
REQ-009 r_ack  input  1  receiver acknowledge, 4-phase, level.
REQ-010 xfer_count  output  16  completed-transfer count; present only with CHANNEL_COUNT_EN.

Function
REQ-011 The block SHALL implement a one-token buffered channel using 4-phase bundled-data handshakes (req up, ack up, req down, ack down) on both sides.
REQ-012 Internal flag full SHALL mark a captured, unconsumed token.
REQ-013 Sender FSM states SHALL be S_IDLE (s_ack=0) and S_ACK (s_ack=1).
REQ-014 S_IDLE->S_ACK at an edge sampling s_req=1 and full=0. On that edge: capture s_data into r_data, set full, set s_ack=1.
REQ-015 S_ACK->S_IDLE at the edge sampling s_req=0. s_ack=0 on that edge.
REQ-016 In S_IDLE, s_req=1 with full=1 SHALL stall. s_ack stays 0 until full clears.
REQ-017 s_req withdrawn before capture SHALL abort the transfer with no capture.
REQ-018 Receiver FSM states SHALL be R_IDLE, R_REQ and R_RTZ.
REQ-019 R_IDLE->R_REQ at an edge where full=1. r_req=1 on that edge.
REQ-020 R_REQ->R_RTZ at an edge sampling r_ack=1. On that edge: r_req=0, full cleared, token consumed.
REQ-021 R_RTZ->R_IDLE at the edge sampling r_ack=0.
REQ-022 r_ack=1 sampled in R_IDLE SHALL be ignored.
REQ-023 Minimum latency from s_req sampled high to r_req high SHALL be 2 edges.
REQ-024 Minimum full-cycle throughput is 1 token per 4 edges. Back-to-back tokens SHALL be neither lost nor duplicated.
REQ-025 Simultaneous capture and consume on one edge SHALL NOT occur. Capture uses the registered full value, so a new capture happens at the earliest on the edge after full clears.
REQ-026 r_data SHALL hold its value after consumption until the next capture.
REQ-027 Data SHALL pass unmodified, full WIDTH bits, with no arithmetic applied.

Reset
REQ-028 rst=1 SHALL immediately force s_ack=0, r_req=0, r_data=0, full=0, S_IDLE and R_IDLE, with no clock required.
REQ-029 rst=1 SHALL clear xfer_count to 0 when CHANNEL_COUNT_EN is compiled in.
REQ-030 Reset asserted mid-transfer SHALL discard the token. After release, the sender must first drop s_req, or the token is recaptured as new.
REQ-031 The first capture SHALL occur no earlier than the first rising edge after rst deasserts.

Configuration
REQ-032 With macro CHANNEL_COUNT_EN defined, port xfer_count SHALL exist and increment by 1, wrapping at 65535->0, on every R_REQ->R_RTZ edge.
REQ-033 Without CHANNEL_COUNT_EN, port xfer_count and its logic SHALL be absent. All other behaviour is identical.

Verification
REQ-034 Single transfer, WIDTH=8, s_data=0x2A, s_req=1:
- s_ack=1 at edge 1 and r_req=1, r_data=0x2A at edge 2.
- Receiver raises r_ack: r_req=0 the next edge.
- Both sides return to zero; xfer_count=1.
REQ-035 Stall: receiver never acks the first token (0x05); sender then offers 0x06.
- s_ack for 0x06 stays 0 and r_data stays 0x05.
- After r_ack, 0x06 is captured no earlier than the edge after full clears.
REQ-036 Stream of tokens 0x00..0xFF with random handshake delays on both sides -> receiver gets exactly 256 tokens in order; xfer_count=256.
REQ-037 Reset mid-transfer, asserted asynchronously between edges while r_req=1 with token 0x77 -> r_req, s_ack, r_data go to 0 immediately; 0x77 is never delivered.
REQ-038 Protocol noise:
- Spurious r_ack=1 in R_IDLE -> no state change.
- s_req pulse shorter than one clock period, falling before the next edge -> no capture, s_ack stays 0.

Source files
------------

// File: rtl/channel.sv
// channel: one-token buffered channel, 4-phase bundled-data handshakes on both sides; define CHANNEL_COUNT_EN to add xfer_count
module channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_req,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ack,
    output logic             r_req,
    output logic [WIDTH-1:0] r_data,
    input  logic             r_ack
`ifdef CHANNEL_COUNT_EN
    ,
    output logic [15:0]      xfer_count
`endif
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_RTZ  = 2'd2;

    logic [0:0] s_st, s_nxt;
    logic [1:0] r_st, r_nxt;
    logic       full, capture, consume;

    // capture looks at registered full, so it can never coincide with consume
    always_comb begin
        capture = s_st == S_IDLE && s_req && !full;
        consume = r_st == R_REQ && r_ack;
        s_nxt   = capture ? S_ACK : (s_st == S_ACK && !s_req) ? S_IDLE : s_st;
        r_nxt   = (r_st == R_IDLE && full) ? R_REQ :
                  consume                  ? R_RTZ :
                  (r_st == R_RTZ && !r_ack) ? R_IDLE :
                  (r_st == 2'd3)           ? R_IDLE : r_st;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_st   <= S_IDLE;
            r_st   <= R_IDLE;
            full   <= 1'b0;
            s_ack  <= 1'b0;
            r_req  <= 1'b0;
            r_data <= '0;
        end else begin
            s_st   <= s_nxt;
            r_st   <= r_nxt;
            full   <= capture | (full & !consume);
            s_ack  <= s_nxt == S_ACK;
            r_req  <= r_nxt == R_REQ;
            if (capture)
                r_data <= s_data;
        end
    end

`ifdef CHANNEL_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xfer_count <= '0;
        else if (consume)
            xfer_count <= xfer_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_channel.sv
// tb_channel: directed self-checking bench for channel
module tb_channel;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_req = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ack;
    logic       r_req;
    logic [7:0] r_data;
    logic       r_ack = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         rx_count = 0;
`ifdef CHANNEL_COUNT_EN
    logic [15:0] xfer_count;
`endif

    channel #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .s_req(s_req),
        .s_data(s_data),
        .s_ack(s_ack),
        .r_req(r_req),
        .r_data(r_data),
        .r_ack(r_ack)
`ifdef CHANNEL_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_check(input string tag, input int exp);
`ifdef CHANNEL_COUNT_EN
        check(tag, {16'd0, xfer_count}, exp);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_s_ack", s_ack, 0);
        check("rst_r_req", r_req, 0);
        check("rst_r_data", r_data, 0);
        count_check("rst_count", 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_s_ack", s_ack, 0);

        // single transfer
        s_data = 8'h2A; s_req = 1'b1;
        tick();
        check("t1_s_ack_e1", s_ack, 1);
        check("t1_r_req_e1", r_req, 0);
        tick();
        check("t1_r_req_e2", r_req, 1);
        check("t1_r_data_e2", r_data, 8'h2A);
        s_req = 1'b0; r_ack = 1'b1;
        tick();
        check("t1_r_req_e3", r_req, 0);
        check("t1_s_ack_e3", s_ack, 0);
        r_ack = 1'b0;
        tick();
        check("t1_r_req_e4", r_req, 0);
        count_check("t1_count", 1);

        // stall: first token held, second offered
        s_data = 8'h05; s_req = 1'b1;
        tick();
        check("st_s_ack_05", s_ack, 1);
        s_req = 1'b0;
        tick();
        check("st_r_req_05", r_req, 1);
        s_data = 8'h06; s_req = 1'b1;
        tick(); tick(); tick();
        check("st_s_ack_stall", s_ack, 0);
        check("st_r_data_hold", r_data, 8'h05);
        check("st_r_req_hold", r_req, 1);
        r_ack = 1'b1;
        tick();
        check("st_r_req_consume", r_req, 0);
        check("st_s_ack_no_same_edge", s_ack, 0);
        check("st_r_data_after_consume", r_data, 8'h05);
        tick();
        check("st_s_ack_06", s_ack, 1);
        check("st_r_data_06", r_data, 8'h06);
        r_ack = 1'b0; s_req = 1'b0;
        tick();
        check("st_s_ack_rtz", s_ack, 0);
        check("st_r_req_rtz", r_req, 0);
        tick();
        check("st_r_req_06", r_req, 1);
        r_ack = 1'b1;
        tick();
        check("st_r_req_06_done", r_req, 0);
        r_ack = 1'b0;
        tick();
        count_check("st_count", 3);

        // spurious r_ack while receiver idle
        r_ack = 1'b1;
        tick(); tick();
        check("noise_r_req", r_req, 0);
        check("noise_s_ack", s_ack, 0);
        count_check("noise_count", 3);
        r_ack = 1'b0;
        tick();

        // s_req pulse that falls before the next edge
        s_data = 8'hEE; s_req = 1'b1;
        #3 s_req = 1'b0;
        tick();
        check("pulse_s_ack", s_ack, 0);
        check("pulse_r_data", r_data, 8'h06);
        tick();
        check("pulse_r_req", r_req, 0);

        // reset asserted between edges while r_req is high
        s_data = 8'h77; s_req = 1'b1;
        tick();
        s_req = 1'b0;
        tick();
        check("mr_r_req_pre", r_req, 1);
        check("mr_r_data_pre", r_data, 8'h77);
        #2 rst = 1'b1;
        #1;
        check("mr_r_req", r_req, 0);
        check("mr_s_ack", s_ack, 0);
        check("mr_r_data", r_data, 0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        check("mr_r_req_after", r_req, 0);
        check("mr_r_data_after", r_data, 0);
        count_check("mr_count", 0);

        // stream 0x00..0xFF with random handshake delays
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    s_data = 8'(i); s_req = 1'b1;
                    for (int t = 0; t < 60 && !s_ack; t++) tick();
                    if (!s_ack) check("sx_ack_tmo", s_ack, 1);
                    s_req = 1'b0;
                    for (int t = 0; t < 60 && s_ack; t++) tick();
                    if (s_ack) check("sx_rtz_tmo", s_ack, 0);
                end
            end
            begin
                for (int i = 0; i < 256; i++) begin
                    for (int t = 0; t < 80 && !r_req; t++) tick();
                    if (!r_req) check("rx_req_tmo", r_req, 1);
                    check("rx_data", r_data, i);
                    rx_count++;
                    repeat ($urandom_range(0, 3)) tick();
                    r_ack = 1'b1;
                    for (int t = 0; t < 60 && r_req; t++) tick();
                    if (r_req) check("rx_drop_tmo", r_req, 0);
                    repeat ($urandom_range(0, 3)) tick();
                    r_ack = 1'b0;
                    tick();
                end
            end
        join
        tick(); tick(); tick();
        check("rx_count", rx_count, 256);
        check("rx_no_extra", r_req, 0);
        count_check("stream_count", 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
